// File: rtl/mips_pkg.sv
// Shared types for the MIPS front end: fetch FSM states and queue entry layout.
package mips_pkg;

  localparam int unsigned INSTR_W = 32;

  // IDLE: nothing outstanding; WAIT: response will be kept; DROP: response will be discarded.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StDrop = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of {pc, instr} entries between instruction memory and the datapath.
// Flush wins over push and pop; the head reads as zero whenever the queue is empty.
module fetch_queue
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PtrW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  fetch_entry_t push_entry_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output logic [PtrW:0] count_o,
  output fetch_entry_t head_o
);

  fetch_entry_t    mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]   count_q, count_d;

  // Storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) begin
      mem_q[wr_ptr_q] <= push_entry_i;
    end
  end

  // Pointer and occupancy update; DEPTH is a power of two so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + (PtrW+1)'(push_i) - (PtrW+1)'(pop_i);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count_o = count_q;
  assign head_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, keeps one request in flight to instruction memory,
// and buffers returned words for the datapath. A redirect flushes and restarts fetch.
module instr_fetch
  import mips_pkg::*;
#(
  parameter logic [INSTR_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned        DEPTH    = 2
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [INSTR_W-1:0] imem_req_addr,
  input  logic               imem_resp_valid,
  input  logic [INSTR_W-1:0] imem_resp_data,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [INSTR_W-1:0] instr_pc,
  input  logic               redirect,
  input  logic [INSTR_W-1:0] redirect_pc
);

  localparam int unsigned   PtrW     = $clog2(DEPTH);
  localparam logic [PtrW:0] DepthCnt = (PtrW+1)'(DEPTH);

  fetch_state_e       state_q, state_d;
  logic [INSTR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [INSTR_W-1:0] req_pc_q, req_pc_d;
  logic [PtrW:0]      count;
  logic               req_fire;
  logic               push;
  logic               pop;
  fetch_entry_t       push_entry;
  fetch_entry_t       head;
  logic               unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // A request reserves a queue slot, so a later push can never find the queue full.
  assign imem_req_valid = !reset && (state_q == StIdle) && (count < DepthCnt);
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign instr_valid = (count != '0);
  assign instr       = head.instr;
  assign instr_pc    = head.pc;
  assign pop         = instr_valid && instr_ready && !redirect;

  assign push_entry.pc    = req_pc_q;
  assign push_entry.instr = imem_resp_data;

  // Next-state logic; a redirect overrides everything decided by the normal flow.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    push       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_fire) begin
          fetch_pc_d = fetch_pc_q + 32'd4;
          req_pc_d   = fetch_pc_q;
          state_d    = StWait;
        end
      end
      StWait: begin
        if (imem_resp_valid) begin
          push    = 1'b1;
          state_d = StIdle;
        end
      end
      StDrop: begin
        if (imem_resp_valid) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (redirect) begin
      fetch_pc_d = {redirect_pc[INSTR_W-1:2], 2'b00};
      push       = 1'b0;
      // Any request still in flight after this edge must have its response discarded.
      if (state_q == StIdle) begin
        state_d = req_fire ? StDrop : StIdle;
      end else begin
        state_d = imem_resp_valid ? StIdle : StDrop;
      end
    end
  end

  // FSM and PC registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      fetch_pc_q <= {RESET_PC[INSTR_W-1:2], 2'b00};
      req_pc_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_fetch_queue (
    .clk          (clk),
    .reset        (reset),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .flush_i      (redirect),
    .count_o      (count),
    .head_o       (head)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: streaming, backpressure, redirects, reset, PC wrap.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        redirect;
  logic [31:0] redirect_pc;

  // Second instance starting near the top of the address space.
  logic        reset2;
  logic        req_valid2;
  logic [31:0] req_addr2;
  logic        resp_valid2;
  logic [31:0] resp_data2;
  logic        instr_valid2;
  logic [31:0] instr2;
  logic [31:0] instr_pc2;
  logic        one;
  logic        zero;
  logic [31:0] zero32;

  int n_cmp = 0;
  int n_err = 0;

  assign one    = 1'b1;
  assign zero   = 1'b0;
  assign zero32 = 32'h0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // Memory model 1: answers the cycle after acceptance unless resp_en holds it back.
  logic        resp_en;
  logic        pend_q;
  logic [31:0] pend_addr_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q <= 1'b0;
    end else if (imem_req_valid && imem_req_ready) begin
      pend_q      <= 1'b1;
      pend_addr_q <= imem_req_addr;
    end else if (pend_q && resp_en) begin
      pend_q <= 1'b0;
    end
  end
  assign imem_resp_valid = pend_q && resp_en;
  assign imem_resp_data  = imem_resp_valid ? mem_word(pend_addr_q) : 32'h0;

  // Memory model 2: always ready, zero wait.
  logic        pend2_q;
  logic [31:0] pend2_addr_q;
  always_ff @(posedge clk) begin
    if (reset2) begin
      pend2_q <= 1'b0;
    end else if (req_valid2) begin
      pend2_q      <= 1'b1;
      pend2_addr_q <= req_addr2;
    end else begin
      pend2_q <= 1'b0;
    end
  end
  assign resp_valid2 = pend2_q;
  assign resp_data2  = pend2_q ? mem_word(pend2_addr_q) : 32'h0;

  instr_fetch #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (2)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc)
  );

  instr_fetch #(
    .RESET_PC (32'hFFFF_FFF8),
    .DEPTH    (2)
  ) dut_wrap (
    .clk             (clk),
    .reset           (reset2),
    .imem_req_valid  (req_valid2),
    .imem_req_ready  (one),
    .imem_req_addr   (req_addr2),
    .imem_resp_valid (resp_valid2),
    .imem_resp_data  (resp_data2),
    .instr_valid     (instr_valid2),
    .instr_ready     (one),
    .instr           (instr2),
    .instr_pc        (instr_pc2),
    .redirect        (zero),
    .redirect_pc     (zero32)
  );

  task automatic test_reset();
    @(negedge clk);
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_err++;
      $display("FAIL rst_req_valid got %b want 0", imem_req_valid); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++;
      $display("FAIL rst_instr_valid got %b want 0", instr_valid); end
    n_cmp++; if (instr !== 32'h0) begin n_err++;
      $display("FAIL rst_instr got %h want 0", instr); end
    n_cmp++; if (instr_pc !== 32'h0) begin n_err++;
      $display("FAIL rst_instr_pc got %h want 0", instr_pc); end
    n_cmp++; if (imem_req_addr !== 32'h0) begin n_err++;
      $display("FAIL rst_req_addr got %h want 0", imem_req_addr); end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (imem_req_valid !== 1'b1) begin n_err++;
      $display("FAIL rel_req_valid got %b want 1", imem_req_valid); end
    n_cmp++; if (imem_req_addr !== 32'h0) begin n_err++;
      $display("FAIL rel_req_addr got %h want 0", imem_req_addr); end
  endtask

  task automatic test_stream();
    logic [31:0] pc;
    imem_req_ready = 1'b1;
    instr_ready    = 1'b1;
    for (int k = 0; k < 4; k++) begin
      pc = 32'(k) * 32'd4;
      @(negedge clk);
      n_cmp++; if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin n_err++;
        $display("FAIL stream_wait k=%0d got req=%b iv=%b want 0 0", k, imem_req_valid,
                 instr_valid); end
      @(negedge clk);
      n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== pc) begin n_err++;
        $display("FAIL stream_pc k=%0d got v=%b pc=%h want 1 %h", k, instr_valid, instr_pc,
                 pc); end
      n_cmp++; if (instr !== mem_word(pc)) begin n_err++;
        $display("FAIL stream_instr k=%0d got %h want %h", k, instr, mem_word(pc)); end
      n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== pc + 32'd4) begin n_err++;
        $display("FAIL stream_addr k=%0d got v=%b a=%h want 1 %h", k, imem_req_valid,
                 imem_req_addr, pc + 32'd4); end
    end
    imem_req_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (instr_valid !== 1'b0 || imem_req_addr !== 32'h10) begin n_err++;
      $display("FAIL stream_idle got v=%b a=%h want 0 10", instr_valid, imem_req_addr); end
  endtask

  task automatic test_backpressure();
    instr_ready    = 1'b0;
    imem_req_ready = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (imem_req_valid !== 1'b0) begin n_err++;
        $display("FAIL bp_full_req i=%0d got %b want 0", i, imem_req_valid); end
      n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 32'h10 || instr !== mem_word(32'h10))
        begin n_err++;
        $display("FAIL bp_head i=%0d got v=%b pc=%h d=%h want 1 10 %h", i, instr_valid,
                 instr_pc, instr, mem_word(32'h10)); end
      @(negedge clk);
    end
    instr_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 32'h14 || instr !== mem_word(32'h14))
      begin n_err++;
      $display("FAIL bp_second got v=%b pc=%h d=%h want 1 14", instr_valid, instr_pc,
               instr); end
    n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h18) begin n_err++;
      $display("FAIL bp_resume got v=%b a=%h want 1 18", imem_req_valid, imem_req_addr); end
    @(negedge clk);
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++;
      $display("FAIL bp_drain got %b want 0", instr_valid); end
    @(negedge clk);
    n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 32'h18) begin n_err++;
      $display("FAIL bp_third got v=%b pc=%h want 1 18", instr_valid, instr_pc); end
    imem_req_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (instr_valid !== 1'b0 || imem_req_addr !== 32'h1C) begin n_err++;
      $display("FAIL bp_idle got v=%b a=%h want 0 1c", instr_valid, imem_req_addr); end
  endtask

  task automatic test_redirect_wait();
    imem_req_ready = 1'b1;
    resp_en        = 1'b0;
    @(negedge clk);
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_err++;
      $display("FAIL rw_in_wait got %b want 0", imem_req_valid); end
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    @(negedge clk);
    redirect = 1'b0;
    n_cmp++; if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin n_err++;
      $display("FAIL rw_drop got req=%b iv=%b want 0 0", imem_req_valid, instr_valid); end
    resp_en = 1'b1;
    @(negedge clk);
    n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin n_err++;
      $display("FAIL rw_target got v=%b a=%h want 1 100", imem_req_valid, imem_req_addr); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++;
      $display("FAIL rw_dropped_visible got %b want 0", instr_valid); end
    @(negedge clk);
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++;
      $display("FAIL rw_latency got %b want 0", instr_valid); end
    @(negedge clk);
    n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instr !== mem_word(32'h100))
      begin n_err++;
      $display("FAIL rw_first got v=%b pc=%h d=%h want 1 100", instr_valid, instr_pc, instr);
    end
    imem_req_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (instr_valid !== 1'b0 || imem_req_addr !== 32'h104) begin n_err++;
      $display("FAIL rw_idle got v=%b a=%h want 0 104", instr_valid, imem_req_addr); end
  endtask

  task automatic test_redirect_accept();
    imem_req_ready = 1'b1;
    instr_ready    = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 32'h104 || imem_req_valid !== 1'b1)
      begin n_err++;
      $display("FAIL ra_setup got iv=%b pc=%h req=%b want 1 104 1", instr_valid, instr_pc,
               imem_req_valid); end
    instr_ready = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    @(negedge clk);
    redirect = 1'b0;
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++;
      $display("FAIL ra_flush got %b want 0", instr_valid); end
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_err++;
      $display("FAIL ra_drop_state got %b want 0", imem_req_valid); end
    @(negedge clk);
    n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin n_err++;
      $display("FAIL ra_target got v=%b a=%h want 1 200", imem_req_valid, imem_req_addr); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++;
      $display("FAIL ra_no_stale got %b want 0", instr_valid); end
    repeat (2) @(negedge clk);
    n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 32'h200 || instr !== mem_word(32'h200))
      begin n_err++;
      $display("FAIL ra_first got v=%b pc=%h d=%h want 1 200", instr_valid, instr_pc, instr);
    end
  endtask

  task automatic test_reset_mid();
    instr_ready = 1'b0;
    resp_en     = 1'b0;
    @(negedge clk);
    n_cmp++; if (imem_req_valid !== 1'b0 || instr_valid !== 1'b1) begin n_err++;
      $display("FAIL rm_setup got req=%b iv=%b want 0 1", imem_req_valid, instr_valid); end
    reset = 1'b1;
    #1;
    n_cmp++; if (instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 32'h0) begin n_err++;
      $display("FAIL rm_async got v=%b d=%h pc=%h want 0 0 0", instr_valid, instr, instr_pc);
    end
    @(negedge clk);
    n_cmp++; if (instr_valid !== 1'b0 || imem_req_valid !== 1'b0) begin n_err++;
      $display("FAIL rm_held got iv=%b req=%b want 0 0", instr_valid, imem_req_valid); end
    n_cmp++; if (imem_req_addr !== 32'h0) begin n_err++;
      $display("FAIL rm_addr got %h want 0", imem_req_addr); end
    reset       = 1'b0;
    resp_en     = 1'b1;
    instr_ready = 1'b1;
    #1;
    n_cmp++; if (imem_req_valid !== 1'b1) begin n_err++;
      $display("FAIL rm_release got %b want 1", imem_req_valid); end
    @(negedge clk);
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_err++;
      $display("FAIL rm_wait got %b want 0", imem_req_valid); end
    @(negedge clk);
    n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== mem_word(32'h0))
      begin n_err++;
      $display("FAIL rm_restart got v=%b pc=%h d=%h want 1 0", instr_valid, instr_pc, instr);
    end
    n_cmp++; if (imem_req_addr !== 32'h4) begin n_err++;
      $display("FAIL rm_next_addr got %h want 4", imem_req_addr); end
  endtask

  task automatic test_wrap();
    reset2 = 1'b0;
    #1;
    n_cmp++; if (req_valid2 !== 1'b1 || req_addr2 !== 32'hFFFF_FFF8) begin n_err++;
      $display("FAIL wrap_a0 got v=%b a=%h want 1 fffffff8", req_valid2, req_addr2); end
    @(negedge clk);
    n_cmp++; if (req_valid2 !== 1'b0) begin n_err++;
      $display("FAIL wrap_wait got %b want 0", req_valid2); end
    @(negedge clk);
    n_cmp++; if (req_valid2 !== 1'b1 || req_addr2 !== 32'hFFFF_FFFC) begin n_err++;
      $display("FAIL wrap_a1 got v=%b a=%h want 1 fffffffc", req_valid2, req_addr2); end
    n_cmp++; if (instr_valid2 !== 1'b1 || instr_pc2 !== 32'hFFFF_FFF8) begin n_err++;
      $display("FAIL wrap_pc0 got v=%b pc=%h want 1 fffffff8", instr_valid2, instr_pc2); end
    repeat (2) @(negedge clk);
    n_cmp++; if (req_valid2 !== 1'b1 || req_addr2 !== 32'h0) begin n_err++;
      $display("FAIL wrap_a2 got v=%b a=%h want 1 0", req_valid2, req_addr2); end
    n_cmp++; if (instr_pc2 !== 32'hFFFF_FFFC || instr2 !== mem_word(32'hFFFF_FFFC)) begin
      n_err++;
      $display("FAIL wrap_pc1 got pc=%h d=%h want fffffffc", instr_pc2, instr2); end
    repeat (2) @(negedge clk);
    n_cmp++; if (instr_pc2 !== 32'h0 || instr2 !== mem_word(32'h0) || req_addr2 !== 32'h4)
      begin n_err++;
      $display("FAIL wrap_pc2 got pc=%h d=%h a=%h want 0 %h 4", instr_pc2, instr2, req_addr2,
               mem_word(32'h0)); end
  endtask

  initial begin
    reset          = 1'b1;
    reset2         = 1'b1;
    imem_req_ready = 1'b0;
    instr_ready    = 1'b0;
    redirect       = 1'b0;
    redirect_pc    = 32'h0;
    resp_en        = 1'b1;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_wait();
    test_redirect_accept();
    test_reset_mid();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
